// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM that steps the LEGv8 datapath through
// FETCH/DECODE/EXEC/MEM/WB, with a bounded data-memory wait and a HALT trap.
// Ports: CLK, resetl (sync, active-high), run, opcode[10:0], zero, mem_ready
//   in; pc_write, pc_sel, ir_write, reg2loc, alusrc, mem2reg, reg_write,
//   mem_read, mem_write, aluop[3:0], signop[1:0], state[2:0], halted out.
// Optional MCSEQ_PERF_EN adds cycle_count[31:0] and instr_count[31:0].
module multicycle_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        run,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        ir_write,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  aluop,
    output logic [1:0]  signop,
    output logic [2:0]  state,
    output logic        halted
`ifdef MCSEQ_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    localparam logic [1:0] EXT_D  = 2'b00;
    localparam logic [1:0] EXT_B  = 2'b01;
    localparam logic [1:0] EXT_CB = 2'b10;
    localparam logic [1:0] EXT_MZ = 2'b11;

    // The counter is only 4 bits wide, so a larger limit behaves as 15.
    localparam int         WCLAMP = (WAIT_MAX > 15) ? 15 : WAIT_MAX;
    localparam logic [3:0] WMAX   = 4'(WCLAMP);

    state_t     st;
    logic [3:0] wait_cnt;

    logic is_ldur, is_stur, is_add, is_sub, is_and;
    logic is_orr, is_cbz, is_b, is_movz;
    logic       legal;
    logic       op_alusrc;
    logic [3:0] op_aluop;
    logic [1:0] op_signop;

    assign is_ldur = (opcode == 11'b11111000010);
    assign is_stur = (opcode == 11'b11111000000);
    assign is_add  = (opcode == 11'b10001011000);
    assign is_sub  = (opcode == 11'b11001011000);
    assign is_and  = (opcode == 11'b10001010000);
    assign is_orr  = (opcode == 11'b10101010000);
    assign is_cbz  = (opcode[10:3] == 8'b10110100);
    assign is_b    = (opcode[10:5] == 6'b000101);
    assign is_movz = (opcode[10:2] == 9'b110100101);

    always_comb begin
        legal     = 1'b1;
        op_alusrc = 1'b0;
        op_aluop  = ALU_AND;
        op_signop = EXT_D;
        unique case (1'b1)
            is_ldur, is_stur: begin
                op_alusrc = 1'b1;
                op_aluop  = ALU_ADD;
            end
            is_add: op_aluop = ALU_ADD;
            is_sub: op_aluop = ALU_SUB;
            is_and: op_aluop = ALU_AND;
            is_orr: op_aluop = ALU_ORR;
            is_cbz: begin
                op_aluop  = ALU_PASS;
                op_signop = EXT_CB;
            end
            is_b: op_signop = EXT_B;
            is_movz: begin
                op_alusrc = 1'b1;
                op_aluop  = ALU_PASS;
                op_signop = EXT_MZ;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            st       <= FETCH;
            wait_cnt <= 4'd0;
            halted   <= 1'b0;
        end else begin
            unique case (st)
                FETCH: if (run) st <= DECODE;
                DECODE: begin
                    if (legal) begin
                        st <= EXEC;
                    end else begin
                        st     <= HALT;
                        halted <= 1'b1;
                    end
                end
                EXEC: begin
                    wait_cnt <= 4'd0;
                    if (is_ldur || is_stur) st <= MEM;
                    else if (is_b || is_cbz) st <= FETCH;
                    else st <= WB;
                end
                MEM: begin
                    // Completion is tested first so it wins at the limit.
                    if (mem_ready) begin
                        st <= is_ldur ? WB : FETCH;
                    end else if (wait_cnt >= WMAX) begin
                        st     <= HALT;
                        halted <= 1'b1;
                    end else if (wait_cnt != 4'hF) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WB: st <= FETCH;
                HALT: st <= HALT;
                default: begin
                    st     <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign state = st;

    always_comb begin
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        ir_write  = 1'b0;
        reg2loc   = 1'b0;
        alusrc    = 1'b0;
        mem2reg   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        aluop     = 4'b0000;
        signop    = 2'b00;
        if (!resetl) begin
            unique case (st)
                FETCH: begin
                    ir_write = run;
                    pc_write = run;
                end
                DECODE: begin
                    reg2loc = is_stur | is_cbz;
                    signop  = op_signop;
                end
                EXEC: begin
                    alusrc = op_alusrc;
                    aluop  = op_aluop;
                    signop = op_signop;
                    if (is_b) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end
                    if (is_cbz) begin
                        pc_write = zero;
                        pc_sel   = 1'b1;
                    end
                end
                MEM: begin
                    mem_read  = is_ldur;
                    mem_write = is_stur;
                end
                WB: begin
                    reg_write = 1'b1;
                    mem2reg   = is_ldur;
                end
                default: ;
            endcase
        end
    end

`ifdef MCSEQ_PERF_EN
    // An instruction retires when control returns to FETCH from a
    // working state; a HALT exit never counts.
    logic retire;
    assign retire = (st == WB)
                 || (st == EXEC && (is_b || is_cbz))
                 || (st == MEM && mem_ready && is_stur);

    always_ff @(posedge CLK) begin
        if (resetl) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (run) cycle_count <= cycle_count + 32'd1;
            if (retire) instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: cycle-by-cycle scoreboard bench for the
// multicycle_sequencer control FSM.
module tb_multicycle_sequencer;

    logic        CLK = 1'b0;
    logic        resetl, run, zero, mem_ready;
    logic [10:0] opcode;
    logic        pc_write, pc_sel, ir_write, reg2loc, alusrc, mem2reg;
    logic        reg_write, mem_read, mem_write, halted;
    logic [3:0]  aluop;
    logic [1:0]  signop;
    logic [2:0]  state;
`ifdef MCSEQ_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    always #5 CLK = ~CLK;

    multicycle_sequencer #(.WAIT_MAX(15)) dut (
        .CLK(CLK), .resetl(resetl), .run(run), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write),
        .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg),
        .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .aluop(aluop), .signop(signop),
        .state(state), .halted(halted)
`ifdef MCSEQ_PERF_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110110;
    localparam logic [10:0] OP_MOVZ = 11'b11010010101;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    // Bit order: pc_write pc_sel ir_write reg2loc alusrc mem2reg
    //            reg_write mem_read mem_write
    localparam logic [8:0] S_NONE = 9'b000_000_000;
    localparam logic [8:0] S_FET  = 9'b101_000_000;
    localparam logic [8:0] S_R2L  = 9'b000_100_000;
    localparam logic [8:0] S_ASRC = 9'b000_010_000;
    localparam logic [8:0] S_BR   = 9'b110_000_000;
    localparam logic [8:0] S_PCS  = 9'b010_000_000;
    localparam logic [8:0] S_RW   = 9'b000_000_100;
    localparam logic [8:0] S_LDWB = 9'b000_001_100;
    localparam logic [8:0] S_MRD  = 9'b000_000_010;
    localparam logic [8:0] S_MWR  = 9'b000_000_001;

    int checks   = 0;
    int failures = 0;

    logic [18:0] exp_q[$];
    string       tag_q[$];

    logic [18:0] obs;
    assign obs = {state, halted, pc_write, pc_sel, ir_write, reg2loc,
                  alusrc, mem2reg, reg_write, mem_read, mem_write,
                  aluop, signop};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [18:0] ov(input logic [2:0] st,
                                       input logic [8:0] s,
                                       input logic [3:0] a,
                                       input logic [1:0] g,
                                       input logic h);
        return {st, h, s, a, g};
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, and compare
    // them mid-cycle once the DUT has settled.
    task automatic step(input string tag, input logic r, input logic z,
                        input logic mr, input logic [18:0] e);
        run       = r;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge CLK);
        chk(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
        @(posedge CLK);
        #1;
    endtask

    task automatic fet(input string tag, input logic [10:0] opc);
        opcode = opc;
        step(tag, 1'b1, 1'b0, 1'b1, ov(3'd0, S_FET, 4'b0000, 2'b00, 1'b0));
    endtask

    task automatic rst_cyc(input string tag);
        resetl = 1'b1;
        @(negedge CLK);
        chk(tag, 32'({pc_write, ir_write, reg_write, mem_read, mem_write}),
            32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic rtype(input string tag, input logic [10:0] opc,
                         input logic [3:0] a);
        fet({tag, " F"}, opc);
        step({tag, " D"}, 1, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b00, 0));
        step({tag, " E"}, 1, 0, 1, ov(3'd2, S_NONE, a, 2'b00, 0));
        step({tag, " W"}, 1, 0, 1, ov(3'd4, S_RW, 4'b0000, 2'b00, 0));
    endtask

    initial begin
        resetl    = 1'b1;
        run       = 1'b1;
        zero      = 1'b0;
        mem_ready = 1'b1;
        opcode    = OP_ADD;

        rst_cyc("rst c1");
        step("rst c2", 1, 0, 1, ov(3'd0, S_NONE, 4'b0000, 2'b00, 0));
        resetl = 1'b0;

        rtype("ADD", OP_ADD, 4'b0010);
        rtype("SUB", OP_SUB, 4'b0110);
        rtype("AND", OP_AND, 4'b0000);
        rtype("ORR", OP_ORR, 4'b0001);

        fet("LD F", OP_LDUR);
        step("LD D", 1, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b00, 0));
        step("LD E", 1, 0, 1, ov(3'd2, S_ASRC, 4'b0010, 2'b00, 0));
        for (int i = 0; i < 3; i++)
            step($sformatf("LD wait%0d", i), 1, 0, 0,
                 ov(3'd3, S_MRD, 4'b0000, 2'b00, 0));
        step("LD M", 1, 0, 1, ov(3'd3, S_MRD, 4'b0000, 2'b00, 0));
        step("LD W", 1, 0, 1, ov(3'd4, S_LDWB, 4'b0000, 2'b00, 0));

        fet("ST F", OP_STUR);
        step("ST D", 1, 0, 1, ov(3'd1, S_R2L, 4'b0000, 2'b00, 0));
        step("ST E", 1, 0, 1, ov(3'd2, S_ASRC, 4'b0010, 2'b00, 0));
        step("ST M", 1, 0, 1, ov(3'd3, S_MWR, 4'b0000, 2'b00, 0));

        fet("CBZ1 F", OP_CBZ);
        step("CBZ1 D", 1, 1, 1, ov(3'd1, S_R2L, 4'b0000, 2'b10, 0));
        step("CBZ1 E", 1, 1, 1, ov(3'd2, S_BR, 4'b0111, 2'b10, 0));

        fet("CBZ0 F", OP_CBZ);
        step("CBZ0 D", 1, 0, 1, ov(3'd1, S_R2L, 4'b0000, 2'b10, 0));
        step("CBZ0 E", 1, 0, 1, ov(3'd2, S_PCS, 4'b0111, 2'b10, 0));

        fet("B F", OP_B);
        step("B D", 1, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b01, 0));
        step("B E", 1, 0, 1, ov(3'd2, S_BR, 4'b0000, 2'b01, 0));

        fet("MOVZ F", OP_MOVZ);
        step("MOVZ D", 1, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b11, 0));
        step("MOVZ E", 1, 0, 1, ov(3'd2, S_ASRC, 4'b0111, 2'b11, 0));
        step("MOVZ W", 1, 0, 1, ov(3'd4, S_RW, 4'b0000, 2'b00, 0));

        for (int i = 0; i < 2; i++)
            step("idle", 0, 0, 1, ov(3'd0, S_NONE, 4'b0000, 2'b00, 0));

        fet("RUNDROP F", OP_ADD);
        step("RUNDROP D", 0, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b00, 0));
        step("RUNDROP E", 0, 0, 1, ov(3'd2, S_NONE, 4'b0010, 2'b00, 0));
        step("RUNDROP W", 0, 0, 1, ov(3'd4, S_RW, 4'b0000, 2'b00, 0));
        for (int i = 0; i < 2; i++)
            step("hold", 0, 0, 1, ov(3'd0, S_NONE, 4'b0000, 2'b00, 0));

        fet("EDGE F", OP_STUR);
        step("EDGE D", 1, 0, 1, ov(3'd1, S_R2L, 4'b0000, 2'b00, 0));
        step("EDGE E", 1, 0, 1, ov(3'd2, S_ASRC, 4'b0010, 2'b00, 0));
        for (int i = 0; i < 15; i++)
            step($sformatf("EDGE wait%0d", i), 1, 0, 0,
                 ov(3'd3, S_MWR, 4'b0000, 2'b00, 0));
        step("EDGE done", 1, 0, 1, ov(3'd3, S_MWR, 4'b0000, 2'b00, 0));

        fet("BAD F", OP_BAD);
        step("BAD D", 1, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b00, 0));
        for (int i = 0; i < 10; i++)
            step($sformatf("halt%0d", i), 1, 0, 1,
                 ov(3'd5, S_NONE, 4'b0000, 2'b00, 1));
        rst_cyc("halt rst");
        resetl = 1'b0;

        fet("MR F", OP_LDUR);
        step("MR D", 1, 0, 1, ov(3'd1, S_NONE, 4'b0000, 2'b00, 0));
        step("MR E", 1, 0, 1, ov(3'd2, S_ASRC, 4'b0010, 2'b00, 0));
        for (int i = 0; i < 2; i++)
            step("MR M", 1, 0, 0, ov(3'd3, S_MRD, 4'b0000, 2'b00, 0));
        mem_ready = 1'b0;
        rst_cyc("mem rst");
        resetl = 1'b0;

        fet("TO F", OP_STUR);
        step("TO D", 1, 0, 1, ov(3'd1, S_R2L, 4'b0000, 2'b00, 0));
        step("TO E", 1, 0, 1, ov(3'd2, S_ASRC, 4'b0010, 2'b00, 0));
        for (int i = 0; i < 16; i++)
            step($sformatf("TO wait%0d", i), 1, 0, 0,
                 ov(3'd3, S_MWR, 4'b0000, 2'b00, 0));
        for (int i = 0; i < 2; i++)
            step("TO halt", 1, 0, 0, ov(3'd5, S_NONE, 4'b0000, 2'b00, 1));
`ifdef MCSEQ_PERF_EN
        chk("instr_count", instr_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Control FSM that runs the LEGv8 datapath as a multicycle machine. One instruction is executed over 3–5 states plus data-memory wait states. The block sits beside the register file, ALU, sign extender, data memory and PC/IR registers, and replaces the purely combinational opcode decoder. Each datapath element receives its strobes and selects only in the state where that element is used.

## Interface
Parameters:
- WAIT_MAX, default 15: maximum data-memory wait cycles before a bus fault is declared.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- resetl  in  1  reset, synchronous, active-high
- run  in  1  level enable; when low, the FSM holds in FETCH
- opcode  in  11  instruction[31:21] from the IR; stable from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  data memory completion, sampled in MEM
- pc_write  out  1  load PC
- pc_sel  out  1  0 = PC+4, 1 = old_pc + extimm<<2
- ir_write  out  1  load IR and old_pc
- reg2loc, alusrc, mem2reg  out  1 each  datapath selects
- reg_write, mem_read, mem_write  out  1 each  strobes
- aluop  out  4  0010 add, 0110 sub, 0000 and, 0001 orr, 0111 pass-B
- signop  out  2  00 D-type, 01 B, 10 CB, 11 MOVZ
- state  out  3  current state code
- halted  out  1  sticky fault indicator

## Operation
- States, in encoding order: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Supported opcodes:
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - CBZ 10110100xxx
  - B 000101xxxxx
  - MOVZ 110100101xx
- FETCH, when run=1: ir_write=1, pc_write=1, pc_sel=0; go to DECODE. When run=0: all strobes 0; stay in FETCH.
- DECODE: reg2loc=1 for STUR and CBZ; signop set per opcode.
  - Unsupported opcode: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: alusrc, aluop and signop set per opcode.
  - LDUR/STUR: go to MEM.
  - ADD/SUB/AND/ORR/MOVZ: go to WB.
  - B: pc_write=1, pc_sel=1; go to FETCH.
  - CBZ: pc_write=zero, pc_sel=1; go to FETCH.
- MEM: mem_read=1 (LDUR) or mem_write=1 (STUR), held until mem_ready=1.
  - LDUR with mem_ready: go to WB.
  - STUR with mem_ready: go to FETCH.
  - Wait counter exceeds WAIT_MAX: go to HALT.
- WB: reg_write=1; mem2reg=1 for LDUR; go to FETCH.
- HALT: all strobes 0; halted=1. Leaves only through reset.
- Strobes (pc_write, ir_write, reg_write, mem_read, mem_write) are asserted only in the states listed above and are 0 in every other state.
- Selects are 0 wherever they are not stated.

## Timing
- Outputs are Moore-decoded from the state register plus opcode. They are valid for the whole cycle, and writes take effect on the next rising edge.
- Reset: in any cycle where resetl=1, all strobes are forced to 0. Next state is FETCH, the wait counter is cleared, and halted is cleared. Reset takes priority over every transition, including mid-MEM.
- Cycles per instruction with no wait states: R-type/MOVZ 4, LDUR 5, STUR 4, B 3, CBZ 3.
- Wait states: each cycle in MEM with mem_ready=0 adds 1 cycle. The 4-bit wait counter clears on MEM entry and saturates.
- Simultaneous events:
  - mem_ready=1 in the same cycle the counter reaches WAIT_MAX: completion wins.
  - run falling mid-instruction: the instruction completes; the FSM then holds in FETCH.

## Configuration
- MCSEQ_PERF_EN defined: adds two 32-bit outputs.
  - cycle_count increments every non-reset cycle while run=1.
  - instr_count increments on each transition into FETCH from EXEC, MEM or WB.
  - Both clear on reset and wrap modulo 2^32.
- MCSEQ_PERF_EN undefined: neither port nor the counters exist.

## Test plan
- Reset with run=1, hold resetl=1 for 2 cycles, then release -> state=0, all strobes 0 during reset, ir_write=1 on the first cycle after release.
- ADD (10001011000), mem_ready=1 -> states 0,1,2,4,0; reg_write high only in cycle 4; aluop=0010.
- LDUR with mem_ready low for 3 cycles -> 8 cycles total; mem_read high for 4 consecutive cycles; mem2reg=1 and reg_write=1 in WB.
- CBZ with zero=1 -> pc_write=1, pc_sel=1 in EXEC. CBZ with zero=0 -> pc_write=0, and the next state is FETCH after 3 cycles.
- Opcode 11111111111 -> HALT after DECODE, halted=1 persists 10 cycles; reset clears it.
- STUR with mem_ready held 0 and WAIT_MAX=15 -> HALT after 16 MEM cycles. With MCSEQ_PERF_EN, instr_count does not increment for this instruction.
